// File: rtl/sar_dms_ctrl.sv
// Successive-approximation ADC controller: walks a trial code MSB to LSB, letting the
// DAC/comparator settle each bit, and publishes the final code with a one-cycle valid pulse.
module sar_dms_ctrl #(
    parameter int N_BITS     = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              cmp_i,
    output logic [N_BITS-1:0] dac_o,
    output logic              busy_o,
    output logic              valid_o,
    output logic [N_BITS-1:0] data_o
);

    localparam int S     = SETTLE_CYC + 2;
    localparam int IDX_W = $clog2(N_BITS);
    localparam int CNT_W = $clog2(S + 1);

    localparam logic [IDX_W-1:0]  IDX_MSB  = IDX_W'(N_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(S - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [N_BITS-1:0] MSB_CODE = {1'b1, {(N_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DECIDE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_BITS-1:0] dac_q, dac_d;
    logic [N_BITS-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [1:0]        sync_q, sync_d;
    logic              cmp_s;
    logic [N_BITS-1:0] trial;

    // Two-flop synchronizer; the settle window of S >= 2 cycles absorbs its latency.
    assign sync_d = {sync_q[0], cmp_i};
    assign cmp_s  = sync_q[1];

    always_comb begin
        state_d = state_q;
        dac_d   = dac_q;
        data_d  = data_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        trial   = dac_q;

        case (state_q)
            IDLE: begin
                dac_d = '0;
                if (start_i) begin
                    state_d = SETTLE;
                    dac_d   = MSB_CODE;
                    idx_d   = IDX_MSB;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DECIDE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DECIDE: begin
                if (!cmp_s) begin
                    trial[idx_q] = 1'b0;
                end
                if (idx_q != '0) begin
                    trial[idx_q - IDX_ONE] = 1'b1;
                    idx_d   = idx_q - IDX_ONE;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    // Result and valid are registered together so both appear in DONE.
                    data_d  = trial;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
                dac_d = trial;
            end
            DONE: begin
                state_d = IDLE;
                dac_d   = '0;
            end
            default: begin
                state_d = IDLE;
                dac_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            dac_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            dac_q   <= dac_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
        end
    end

    assign dac_o   = dac_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q == SETTLE) || (state_q == DECIDE);

endmodule
